// File: rtl/push_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : push_ctrl_pkg
// Purpose  : State encodings, default timing constants and helpers shared by
//            the push-button controller.
// Revision : 1.0  initial release
// ============================================================================
package push_ctrl_pkg;

    localparam int c_STATE_W = 3;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_PRESS = 3'd1;
    localparam logic [2:0] c_ST_DEBP  = 3'd2;
    localparam logic [2:0] c_ST_HELD  = 3'd3;
    localparam logic [2:0] c_ST_REL   = 3'd4;
    localparam logic [2:0] c_ST_DEBR  = 3'd5;

    // 50 MHz defaults: 10 ms debounce, 1 s long press, 100 ms repeat
    localparam int c_DEBOUNCE_MAX_DEF = 500_000;
    localparam int c_HOLD_MAX_DEF     = 50_000_000;
    localparam int c_REPEAT_MAX_DEF   = 5_000_000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_push_control_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_push_control_if
// Purpose  : Button inputs and event outputs of the multi-channel controller.
// Revision : 1.0  initial release
// ============================================================================
interface multi_push_control_if #(
    parameter int NUM_CH = 4
) ();

    logic [NUM_CH-1:0] i_Push;
    logic [NUM_CH-1:0] i_RepeatEn;
    logic [NUM_CH-1:0] o_fPush;
    logic [NUM_CH-1:0] o_fRelease;
    logic [NUM_CH-1:0] o_fHold;
    logic [NUM_CH-1:0] o_Level;

    modport master (
        output i_Push, i_RepeatEn,
        input  o_fPush, o_fRelease, o_fHold, o_Level
    );

    modport slave (
        input  i_Push, i_RepeatEn,
        output o_fPush, o_fRelease, o_fHold, o_Level
    );

endinterface
`default_nettype wire

// File: rtl/push_channel.sv
`default_nettype none
// ============================================================================
// Module   : push_channel
// Purpose  : One button: synchroniser, debounce, long-press and auto-repeat.
// Revision : 1.0  initial release
// ============================================================================
module push_channel
    import push_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_MAX = c_DEBOUNCE_MAX_DEF,
    parameter int HOLD_MAX     = c_HOLD_MAX_DEF,
    parameter int REPEAT_MAX   = c_REPEAT_MAX_DEF
) (
    input  wire  i_Clk,
    input  wire  i_Rst,
    input  wire  i_Push,
    input  wire  i_RepeatEn,
    output logic o_fPush,
    output logic o_fRelease,
    output logic o_fHold,
    output logic o_Level
);

    localparam int c_CNT_W = $clog2(max3(DEBOUNCE_MAX, HOLD_MAX, REPEAT_MAX));
    localparam logic [c_CNT_W-1:0] c_DEB_TC  = c_CNT_W'(DEBOUNCE_MAX - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_TC = c_CNT_W'(HOLD_MAX - 1);
    localparam logic [c_CNT_W-1:0] c_REP_TC  = c_CNT_W'(REPEAT_MAX - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    logic [1:0]           r_sync;
    logic [c_STATE_W-1:0] r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_hold;
    logic                 w_sync;

    assign w_sync = r_sync[1];

    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            r_sync     <= 2'b00;
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_hold     <= 1'b0;
            o_fPush    <= 1'b0;
            o_fRelease <= 1'b0;
            o_fHold    <= 1'b0;
            o_Level    <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], i_Push};
            o_fPush    <= 1'b0;
            o_fRelease <= 1'b0;
            o_fHold    <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_sync) r_state <= c_ST_PRESS;
                end
                // Pulses are issued on leaving PRESS/REL so they line up
                // with the level change.
                c_ST_PRESS: begin
                    r_state <= c_ST_DEBP;
                    r_cnt   <= '0;
                    o_fPush <= 1'b1;
                    o_Level <= 1'b1;
                end
                c_ST_DEBP: begin
                    if (r_cnt == c_DEB_TC) begin
                        if (w_sync) begin
                            r_state <= c_ST_HELD;
                            r_cnt   <= '0;
                            r_hold  <= 1'b0;
                        end else begin
                            r_state <= c_ST_REL;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_HELD: begin
                    if (!w_sync) begin
                        r_state <= c_ST_REL;
                    end else if (!r_hold) begin
                        if (r_cnt == c_HOLD_TC) begin
                            o_fHold <= 1'b1;
                            r_hold  <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end else if (i_RepeatEn) begin
                        if (r_cnt == c_REP_TC) begin
                            o_fPush <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
                c_ST_REL: begin
                    r_state    <= c_ST_DEBR;
                    r_cnt      <= '0;
                    o_fRelease <= 1'b1;
                    o_Level    <= 1'b0;
                end
                c_ST_DEBR: begin
                    if (r_cnt == c_DEB_TC) r_state <= c_ST_IDLE;
                    else                   r_cnt   <= r_cnt + c_CNT_ONE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_cnt   <= '0;
                    r_hold  <= 1'b0;
                    o_Level <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/multi_push_control.sv
`default_nettype none
// ============================================================================
// Module   : multi_push_control
// Purpose  : NUM_CH independent debounced push-button channels.
// Revision : 1.0  initial release
// ============================================================================
module multi_push_control
    import push_ctrl_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int DEBOUNCE_MAX = c_DEBOUNCE_MAX_DEF,
    parameter int HOLD_MAX     = c_HOLD_MAX_DEF,
    parameter int REPEAT_MAX   = c_REPEAT_MAX_DEF
) (
    input  wire                   i_Clk,
    input  wire                   i_Rst,
    multi_push_control_if.slave   bus
);

    wire [NUM_CH-1:0] w_fPush;
    wire [NUM_CH-1:0] w_fRelease;
    wire [NUM_CH-1:0] w_fHold;
    wire [NUM_CH-1:0] w_Level;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            push_channel #(
                .DEBOUNCE_MAX (DEBOUNCE_MAX),
                .HOLD_MAX     (HOLD_MAX),
                .REPEAT_MAX   (REPEAT_MAX)
            ) u_ch (
                .i_Clk      (i_Clk),
                .i_Rst      (i_Rst),
                .i_Push     (bus.i_Push[g]),
                .i_RepeatEn (bus.i_RepeatEn[g]),
                .o_fPush    (w_fPush[g]),
                .o_fRelease (w_fRelease[g]),
                .o_fHold    (w_fHold[g]),
                .o_Level    (w_Level[g])
            );
        end
    endgenerate

    assign bus.o_fPush    = w_fPush;
    assign bus.o_fRelease = w_fRelease;
    assign bus.o_fHold    = w_fHold;
    assign bus.o_Level    = w_Level;

endmodule
`default_nettype wire

// File: tb/tb_multi_push_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_push_control
// Purpose  : Directed checks of multi_push_control (DEB=4, HOLD=20, REP=5).
// Revision : 1.0  initial release
// ============================================================================
module tb_multi_push_control;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    multi_push_control_if #(.NUM_CH(4)) bus ();

    multi_push_control #(
        .NUM_CH       (4),
        .DEBOUNCE_MAX (4),
        .HOLD_MAX     (20),
        .REPEAT_MAX   (5)
    ) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus)
    );

    int n_err    = 0;
    int n_checks = 0;
    int e        = -1;
    int cnt_push [4];
    int cnt_rel  [4];
    int cnt_hold [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Edge index e is relative to the scenario; outputs sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
        e++;
        for (int c = 0; c < 4; c++) begin
            cnt_push[c] += int'(bus.o_fPush[c]);
            cnt_rel[c]  += int'(bus.o_fRelease[c]);
            cnt_hold[c] += int'(bus.o_fHold[c]);
        end
    endtask

    task automatic run_to(input int target);
        while (e < target) tick();
    endtask

    task automatic do_reset();
        bus.i_Push     = 4'b0000;
        bus.i_RepeatEn = 4'b0000;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        e = -1;
        for (int c = 0; c < 4; c++) begin
            cnt_push[c] = 0;
            cnt_rel[c]  = 0;
            cnt_hold[c] = 0;
        end
    endtask

    initial begin
        // Reset state and clean press/release on ch0
        do_reset();
        chk("reset_outputs", {16'h0, bus.o_fPush, bus.o_fRelease, bus.o_fHold, bus.o_Level}, 32'h0);
        bus.i_Push = 4'b0001;
        run_to(2);
        chk("A_push_e2", bus.o_fPush, 4'b0000);
        run_to(3);
        chk("A_push_e3", bus.o_fPush, 4'b0001);
        chk("A_level_e3", bus.o_Level, 4'b0001);
        run_to(4);
        chk("A_push_e4", bus.o_fPush, 4'b0000);
        run_to(27);
        chk("A_hold_e27", bus.o_fHold, 4'b0001);
        run_to(49);
        bus.i_Push = 4'b0000;
        run_to(52);
        chk("A_rel_e52", bus.o_fRelease, 4'b0000);
        chk("A_level_e52", bus.o_Level, 4'b0001);
        run_to(53);
        chk("A_rel_e53", bus.o_fRelease, 4'b0001);
        chk("A_level_e53", bus.o_Level, 4'b0000);
        run_to(54);
        chk("A_rel_e54", bus.o_fRelease, 4'b0000);
        run_to(60);
        chk("A_push_count", cnt_push[0], 1);
        chk("A_other_ch", cnt_push[1] + cnt_push[2] + cnt_push[3] + cnt_rel[1] + cnt_hold[2], 0);

        // Bouncing ch1: 1,0,1 then steady high
        do_reset();
        bus.i_Push = 4'b0010;
        tick();
        bus.i_Push = 4'b0000;
        tick();
        bus.i_Push = 4'b0010;
        run_to(3);
        chk("B_push_e3", bus.o_fPush, 4'b0010);
        run_to(15);
        chk("B_push_count", cnt_push[1], 1);
        chk("B_rel_count", cnt_rel[1], 0);
        chk("B_level_e15", bus.o_Level, 4'b0010);

        // Long hold on ch2, no repeat
        do_reset();
        bus.i_Push = 4'b0100;
        run_to(26);
        chk("C_hold_e26", bus.o_fHold, 4'b0000);
        run_to(27);
        chk("C_hold_e27", bus.o_fHold, 4'b0100);
        run_to(59);
        bus.i_Push = 4'b0000;
        run_to(63);
        chk("C_rel_e63", bus.o_fRelease, 4'b0100);
        run_to(70);
        chk("C_hold_count", cnt_hold[2], 1);
        chk("C_push_count", cnt_push[2], 1);
        chk("C_rel_count", cnt_rel[2], 1);

        // Long hold on ch2 with auto-repeat: pulses at 3, then 32,37,...,57
        do_reset();
        bus.i_Push     = 4'b0100;
        bus.i_RepeatEn = 4'b0100;
        run_to(27);
        chk("D_hold_e27", bus.o_fHold, 4'b0100);
        run_to(31);
        chk("D_push_e31", bus.o_fPush, 4'b0000);
        run_to(32);
        chk("D_push_e32", bus.o_fPush, 4'b0100);
        run_to(37);
        chk("D_push_e37", bus.o_fPush, 4'b0100);
        run_to(59);
        bus.i_Push = 4'b0000;
        run_to(62);
        chk("D_rel_e62", bus.o_fRelease, 4'b0000);
        run_to(63);
        chk("D_rel_e63", bus.o_fRelease, 4'b0100);
        run_to(70);
        chk("D_push_count", cnt_push[2], 7);
        chk("D_hold_count", cnt_hold[2], 1);

        // All channels pressed together
        do_reset();
        bus.i_Push = 4'b1111;
        run_to(2);
        chk("E_push_e2", bus.o_fPush, 4'b0000);
        run_to(3);
        chk("E_push_e3", bus.o_fPush, 4'b1111);
        run_to(4);
        chk("E_push_e4", bus.o_fPush, 4'b0000);
        chk("E_level_e4", bus.o_Level, 4'b1111);

        // Reset pulse while ch3 is held
        do_reset();
        bus.i_Push = 4'b1000;
        run_to(10);
        chk("F_level_held", bus.o_Level, 4'b1000);
        rst = 1'b0;
        run_to(11);
        chk("F_outputs_rst", {16'h0, bus.o_fPush, bus.o_fRelease, bus.o_fHold, bus.o_Level}, 32'h0);
        rst = 1'b1;
        run_to(14);
        chk("F_push_e14", bus.o_fPush, 4'b0000);
        run_to(15);
        chk("F_push_e15", bus.o_fPush, 4'b1000);
        run_to(16);
        chk("F_push_e16", bus.o_fPush, 4'b0000);
        chk("F_level_e16", bus.o_Level, 4'b1000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
